// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default pattern for the serial pattern family
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-in serial-out shift register, MSB first
module piso_shreg #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] DEF   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    // Rotate rather than shift so the captured pattern is restored after WIDTH bits for the next repetition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= DEF;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], sr[WIDTH-1]};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with repeat count, idle gaps and stop request
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               CNT_W       = 8,
    parameter int               GAP_CYCLES  = 0,
    parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(SEQ_DEF_PATTERN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [CNT_W-1:0] rep,
    input  logic             stop,
    output logic             x,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e           state;
    logic [IW-1:0]    bit_idx;
    logic [GW-1:0]    gap_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             stop_flag;
    logic             load;
    logic             shift_en;
    logic             msb;
    logic             stop_now;
    logic             last_rep;

    assign load     = (state == IDLE) && start;
    assign shift_en = (state == SHIFT);
    assign stop_now = stop_flag | stop;
    assign last_rep = (rep_cnt == CNT_W'(1)) || stop_now;

    piso_shreg #(
        .WIDTH (WIDTH),
        .DEF   (DEF_PATTERN)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift_en),
        .din   (pat_in),
        .msb   (msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            rep_cnt   <= '0;
            stop_flag <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rep_cnt   <= rep;
                        bit_idx   <= IW'(WIDTH - 1);
                        state     <= SHIFT;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    stop_flag <= stop_now;
                    if (bit_idx == '0) begin
                        // rep_cnt of zero means continuous, so it is never decremented
                        if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - CNT_W'(1);
                        end
                        if (last_rep) begin
                            state     <= IDLE;
                            stop_flag <= 1'b0;
                            bit_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state     <= GAP;
                            gap_cnt   <= GW'(GAP_CYCLES - 1);
                            bit_valid <= 1'b0;
                        end else begin
                            bit_idx <= IW'(WIDTH - 1);
                        end
                    end else begin
                        bit_idx <= bit_idx - IW'(1);
                    end
                end
                GAP: begin
                    stop_flag <= stop_now;
                    if (gap_cnt == '0) begin
                        if (stop_now) begin
                            state     <= IDLE;
                            stop_flag <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            bit_idx   <= IW'(WIDTH - 1);
                            bit_valid <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign x = msb & bit_valid;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start_g, stop;
    logic [3:0] pat_in;
    logic [7:0] rep;
    logic       x, bit_valid, busy, done;
    logic       x_g, bit_valid_g, busy_g, done_g;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] xv, bvv, bsv, dnv;
    logic [31:0] bits;
    int          nbits;
    int          hits;
    bit          seen_done;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(4), .CNT_W(8), .GAP_CYCLES(0), .DEF_PATTERN(4'b1010)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pat_in    (pat_in),
        .rep       (rep),
        .stop      (stop),
        .x         (x),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    seq_pattern_tx #(.WIDTH(4), .CNT_W(8), .GAP_CYCLES(2), .DEF_PATTERN(4'b1010)) dut_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_g),
        .pat_in    (pat_in),
        .rep       (rep),
        .stop      (stop),
        .x         (x_g),
        .bit_valid (bit_valid_g),
        .busy      (busy_g),
        .done      (done_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample one cycle per bit starting in cycle N+1, oldest sample ending up as the highest bit
    task automatic collect(input int ncyc, input bit gap_inst,
                           output logic [31:0] xo, output logic [31:0] bvo,
                           output logic [31:0] bso, output logic [31:0] dno);
        xo = '0; bvo = '0; bso = '0; dno = '0;
        for (int c = 1; c <= ncyc; c++) begin
            xo  = {xo[30:0],  gap_inst ? x_g         : x};
            bvo = {bvo[30:0], gap_inst ? bit_valid_g : bit_valid};
            bso = {bso[30:0], gap_inst ? busy_g      : busy};
            dno = {dno[30:0], gap_inst ? done_g      : done};
            if (c < ncyc) step();
        end
    endtask

    task automatic kick(input logic [3:0] p, input logic [7:0] r);
        pat_in = p;
        rep    = r;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_g = 1'b0; stop = 1'b0;
        pat_in = 4'b0000; rep = 8'd0;
        #12;
        chk("reset_x",    32'(x),         32'd0);
        chk("reset_bv",   32'(bit_valid), 32'd0);
        chk("reset_busy", 32'(busy),      32'd0);
        chk("reset_done", 32'(done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single repetition
        kick(4'b1010, 8'd1);
        collect(5, 1'b0, xv, bvv, bsv, dnv);
        chk("t1_x",    xv,  32'b10100);
        chk("t1_bv",   bvv, 32'b11110);
        chk("t1_busy", bsv, 32'b11110);
        chk("t1_done", dnv, 32'b00001);

        // three back-to-back repetitions, launched in the done cycle
        kick(4'b1010, 8'd3);
        collect(13, 1'b0, xv, bvv, bsv, dnv);
        chk("t2_x",    xv,  32'b1010101010100);
        chk("t2_bv",   bvv, 32'b1111111111110);
        chk("t2_done", dnv, 32'b0000000000001);
        hits = 0;
        for (int i = 12; i >= 4; i--) begin
            if (xv[i -: 4] == 4'b1010) hits++;
        end
        chk("t2_detect", 32'(hits), 32'd5);

        // gap build, two repetitions with 2 idle cycles between
        step();
        pat_in = 4'b1010; rep = 8'd2; start_g = 1'b1;
        step();
        start_g = 1'b0;
        collect(11, 1'b1, xv, bvv, bsv, dnv);
        chk("t3_x",    xv,  32'b10100010100);
        chk("t3_bv",   bvv, 32'b11110011110);
        chk("t3_busy", bsv, 32'b11111111110);
        chk("t3_done", dnv, 32'b00000000001);

        // stop while idle is ignored; continuous mode stopped during bit 2 of rep 3
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_idle_busy", 32'(busy), 32'd0);
        kick(4'b1100, 8'd0);
        bits = '0; nbits = 0; seen_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bit_valid) begin
                bits = {bits[30:0], x};
                nbits++;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            stop = (c == 10);
            step();
        end
        stop = 1'b0;
        chk("t4_nbits", 32'(nbits), 32'd12);
        chk("t4_bits",  bits,       32'b110011001100);
        chk("t4_done",  32'(seen_done), 32'd1);

        // start re-pulsed while busy, then held through the done cycle
        step();
        kick(4'b1010, 8'd1);
        step();
        pat_in = 4'b0110; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_bit1", 32'(x), 32'd1);
        step();
        chk("t5_bit0", 32'(x), 32'd0);
        start = 1'b1; rep = 8'd1;
        step();
        chk("t5_done_cycle", {30'd0, done, busy}, 32'b10);
        step();
        start = 1'b0;
        collect(5, 1'b0, xv, bvv, bsv, dnv);
        chk("t5_new_x",    xv,  32'b01100);
        chk("t5_new_bv",   bvv, 32'b11110);
        chk("t5_new_done", dnv, 32'b00001);

        // asynchronous reset during bit 2
        step();
        kick(4'b0110, 8'd1);
        step();
        chk("t6_bit2", 32'(x), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_now", {29'd0, x, bit_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done || x || bit_valid || busy) seen_done = 1'b1;
        end
        chk("t6_quiet_after", 32'(seen_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
